// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the core's EX stage and the HI/LO multiply/divide unit.
// The core drives the request side; the unit drives status and the HI/LO contents.
interface mdu_hilo_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             flush;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, op_a, op_b, flush,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, op_a, op_b, flush,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle array multiply.
module mdu_hilo #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic      clk,
   input  logic      rst,
   mdu_hilo_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic                 is_div_q, is_div_d;
   logic                 dz_q, dz_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 dbz_q, dbz_d;

   logic                 is_signed, sign_a, sign_b;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic                 last_iter;
   logic [2*WIDTH-1:0]   prod_signed;
   logic [WIDTH-1:0]     quo_signed, rem_signed;

   // op[0] distinguishes the unsigned variants of MULT/DIV
   assign is_signed = ~bus.op[0];
   assign sign_a    = is_signed & bus.op_a[WIDTH-1];
   assign sign_b    = is_signed & bus.op_b[WIDTH-1];
   assign mag_a     = sign_a ? -bus.op_a : bus.op_a;
   assign mag_b     = sign_b ? -bus.op_b : bus.op_b;

   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
   assign div_shift = {rem_q, acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   assign prod_signed = neg_res_q ? -acc_q : acc_q;
   assign quo_signed  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_signed  = neg_rem_q ? -rem_q : rem_q;

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      rem_d     = rem_q;
      is_div_d  = is_div_q;
      dz_d      = dz_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               case (bus.op)
                  OP_MTHI: hi_d = bus.op_a;
                  OP_MTLO: lo_d = bus.op_a;
                  OP_MULT, OP_MULTU: begin
                     neg_res_d = sign_a ^ sign_b;
                     neg_rem_d = sign_a;
                     is_div_d  = 1'b0;
                     dz_d      = 1'b0;
                     cnt_d     = '0;
                     rem_d     = '0;
                     opnd_d    = mag_a;
`ifdef MDU_FAST_MUL_EN
                     acc_d     = fast_prod;
                     state_d   = FIX;
`else
                     acc_d     = {{WIDTH{1'b0}}, mag_b};
                     state_d   = MUL;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     neg_res_d = sign_a ^ sign_b;
                     neg_rem_d = sign_a;
                     is_div_d  = 1'b1;
                     dz_d      = (bus.op_b == '0);
                     cnt_d     = '0;
                     rem_d     = '0;
                     opnd_d    = mag_b;
                     acc_d     = {{WIDTH{1'b0}}, mag_a};
                     state_d   = (bus.op_b == '0) ? FIX : DIV;
                  end
                  default: ;
               endcase
            end
         end
         MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) state_d = FIX;
         end
         DIV: begin
            // Restore by keeping the shifted value when the trial subtract goes negative
            rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            dbz_d   = dz_q;
            if (!dz_q) begin
               if (is_div_q) begin
                  lo_d = quo_signed;
                  hi_d = rem_signed;
               end else begin
                  hi_d = prod_signed[2*WIDTH-1:WIDTH];
                  lo_d = prod_signed[WIDTH-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.flush && (state_q != IDLE)) begin
         state_d = IDLE;
         done_d  = 1'b0;
         dbz_d   = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         rem_q     <= '0;
         is_div_q  <= 1'b0;
         dz_q      <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         rem_q     <= rem_d;
         is_div_q  <= is_div_d;
         dz_q      <= dz_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: vector table for mul/div/MT ops, then flush and mid-op reset sequences.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_mdu_hilo;
   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_RSVD  = 3'b110;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mdu_hilo_if #(.WIDTH(W)) bus ();
   mdu_hilo #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.op_a  = a;
      bus.op_b  = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Observation j is taken between edges E0+j and E0+j+1
   task automatic wait_done(output int lat, output logic busy_ok, output logic dz);
      lat = -1;
      busy_ok = 1'b1;
      dz = 1'b0;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = j;
            dz = bus.div_by_zero;
            if (bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic busy_ok;
      logic dz;
      logic bad;

      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.flush = 1'b0;

      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT};
      vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, MUL_LAT};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT};
      vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, DIV_LAT};
      vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT};
      vecs[5]  = '{OP_MTHI,  32'h00001234, 32'h0,        32'h00001234, 32'h80000000, 1'b0, 0};
      vecs[6]  = '{OP_MTLO,  32'h00005678, 32'h0,        32'h00001234, 32'h00005678, 1'b0, 0};
      vecs[7]  = '{OP_DIVU,  32'd9,        32'd0,        32'h00001234, 32'h00005678, 1'b1, 1};
      vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT};
      vecs[9]  = '{OP_MULT,  32'd6,        32'd7,        32'h00000000, 32'h0000002A, 1'b0, MUL_LAT};
      vecs[10] = '{OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0, MUL_LAT};
      vecs[11] = '{OP_DIV,   32'd5,        32'd0,        32'h00000001, 32'h00000000, 1'b1, 1};
      vecs[12] = '{OP_RSVD,  32'hDEADBEEF, 32'd3,        32'h00000001, 32'h00000000, 1'b0, 0};

      repeat (2) @(negedge clk);
      chk("rst_hi",   {32'h0, bus.hi}, 64'h0);
      chk("rst_lo",   {32'h0, bus.lo}, 64'h0);
      chk("rst_busy", {63'h0, bus.busy}, 64'h0);
      chk("rst_done", {63'h0, bus.done}, 64'h0);
      chk("rst_dz",   {63'h0, bus.div_by_zero}, 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         if (vecs[i].lat == 0) begin
            bad = 1'b0;
            repeat (3) begin
               @(negedge clk);
               if (bus.busy || bus.done) bad = 1'b1;
            end
            chk($sformatf("v%0d_idle", i), {63'h0, bad}, 64'h0);
            lat = 0;
         end else begin
            wait_done(lat, busy_ok, dz);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), {63'h0, busy_ok}, 64'h1);
            chk($sformatf("v%0d_dz", i), {63'h0, dz}, {63'h0, vecs[i].dz});
         end
         chk($sformatf("v%0d_hi", i), {32'h0, bus.hi}, {32'h0, vecs[i].hi});
         chk($sformatf("v%0d_lo", i), {32'h0, bus.lo}, {32'h0, vecs[i].lo});
         $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, bus.hi, bus.lo, lat);
      end

      // Flush mid-operation; a start while busy must be dropped
`ifdef MDU_FAST_MUL_EN
      issue(OP_DIVU, 32'd42, 32'd6);
`else
      issue(OP_MULT, 32'd6, 32'd7);
`endif
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIV;
      bus.op_a  = 32'd1;
      bus.op_b  = 32'd1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(posedge clk);
      #1 chk("flush_busy", {63'h0, bus.busy}, 64'h0);
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done || bus.busy) bad = 1'b1;
      end
      chk("flush_no_done", {63'h0, bad}, 64'h0);
      chk("flush_hi", {32'h0, bus.hi}, 64'h1);
      chk("flush_lo", {32'h0, bus.lo}, 64'h0);
      $display("flush seq -> hi=%h lo=%h", bus.hi, bus.lo);

      // Asynchronous reset in the middle of a divide
      issue(OP_MTLO, 32'h0000ABCD, 32'h0);
      @(negedge clk);
      chk("mtlo_lo", {32'h0, bus.lo}, 64'hABCD);
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_hi",   {32'h0, bus.hi}, 64'h0);
      chk("arst_lo",   {32'h0, bus.lo}, 64'h0);
      chk("arst_busy", {63'h0, bus.busy}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done || bus.busy) bad = 1'b1;
      end
      chk("arst_no_done", {63'h0, bad}, 64'h0);
      $display("reset seq -> hi=%h lo=%h", bus.hi, bus.lo);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
